// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads a word pair from the combinational instruction
// memory, and hands it to decode over valid/ready with redirect and halt handling.
module fetch_unit #(
  parameter int unsigned         ADDR_W      = 5,
  parameter int unsigned         INSTR_W     = 16,
  parameter logic [3:0]          HALT_OPCODE = 4'b1110,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [INSTR_W-1:0] imem_next,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_next,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic [INSTR_W-1:0]   out_next_q, out_next_d;
  logic [ADDR_W-1:0]    out_pc_q, out_pc_d;
  logic                 halted_q, halted_d;

  logic accept;
  logic slot_free;
  logic is_halt;

  assign accept    = out_valid_q & out_ready;
  assign slot_free = ~out_valid_q | accept;
  assign is_halt   = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_next_d  = out_next_q;
    out_pc_d    = out_pc_q;
    halted_d    = halted_q;

    unique case (state_q)
      RUN: begin
        // Redirect flushes the slot even when decode accepts on the same edge.
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          out_instr_d = imem_instr;
          out_next_d  = imem_next;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + ADDR_W'(1);
          if (is_halt) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The halt is speculative until decode consumes it without a redirect.
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          state_d     = RUN;
        end else if (accept) begin
          out_valid_d = 1'b0;
          halted_d    = 1'b1;
          state_d     = HALTED;
        end
      end
      HALTED: begin
        out_valid_d = 1'b0;
        halted_d    = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_next_q  <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_next_q  <= out_next_d;
      out_pc_q    <= out_pc_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_next  = out_next_q;
  assign out_pc    = out_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: accepted outputs are checked by a scoreboard
// monitor, control/state behaviour by inline checks.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] imem_next;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_next;
  logic [4:0]  out_pc;
  logic        halted;

  fetch_unit #(
    .ADDR_W      (5),
    .INSTR_W     (16),
    .HALT_OPCODE (4'b1110),
    .RESET_PC    (5'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .imem_next      (imem_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_next       (out_next),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  logic [15:0] mem [32];
  logic [4:0]  nxt_addr;
  assign nxt_addr   = imem_addr + 5'd1;
  assign imem_instr = mem[imem_addr];
  assign imem_next  = mem[nxt_addr];

  typedef struct packed {
    logic [4:0]  pc;
    logic [15:0] instr;
    logic [15:0] nxt;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] pc, input logic [15:0] instr, input logic [15:0] nxt);
    exp_t e;
    e.pc = pc; e.instr = instr; e.nxt = nxt;
    sb.push_back(e);
  endtask

  // Monitor: every accepted output must match the next scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", {27'd0, out_pc, out_instr, out_next}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("accept_word", {27'd0, out_pc, out_instr, out_next}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h3000 + 16'(i);
    mem[0]  = 16'h1007;
    mem[1]  = 16'h1102;
    mem[2]  = 16'h2000;
    mem[12] = 16'hE000;
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);

    // First load one cycle after reset, then stall three cycles
    reset = 1'b0;
    step();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc", 64'(out_pc), 64'd0);
    chk("first_instr", 64'(out_instr), 64'h1007);
    chk("first_next", 64'(out_next), 64'h1102);
    chk("first_addr", 64'(imem_addr), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", 64'(out_instr), 64'h1007);
      chk("stall_pc", 64'(out_pc), 64'd0);
      chk("stall_addr", 64'(imem_addr), 64'd1);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end

    // Stream resumes; pc3 is accepted on the same edge as a redirect to 10
    push(5'd0, 16'h1007, 16'h1102);
    push(5'd1, 16'h1102, 16'h2000);
    push(5'd2, 16'h2000, 16'h3003);
    push(5'd3, 16'h3003, 16'h3004);
    out_ready = 1'b1;
    step();
    chk("stream_addr", 64'(imem_addr), 64'd2);
    step(); step();
    chk("stream_pc3", 64'(out_pc), 64'd3);
    chk("stream_addr4", 64'(imem_addr), 64'd4);
    redirect_valid = 1'b1; redirect_pc = 5'd10;
    step();
    chk("redir_flush", 64'(out_valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'd10);
    redirect_valid = 1'b0;

    // Run into the halt word at 12
    push(5'd10, 16'h300A, 16'h300B);
    push(5'd11, 16'h300B, 16'hE000);
    push(5'd12, 16'hE000, 16'h300D);
    step();
    chk("redir_pc", 64'(out_pc), 64'd10);
    chk("redir_instr", 64'(out_instr), 64'h300A);
    step(); step();
    chk("halt_word", 64'(out_instr), 64'hE000);
    chk("halt_addr", 64'(imem_addr), 64'd13);
    step();
    chk("halted", 64'(halted), 64'd1);
    chk("halted_valid", 64'(out_valid), 64'd0);
    chk("halted_addr", 64'(imem_addr), 64'd13);
    redirect_valid = 1'b1; redirect_pc = 5'd5;
    step(); step();
    chk("halt_ign_redir", 64'(halted), 64'd1);
    chk("halt_ign_addr", 64'(imem_addr), 64'd13);
    chk("halt_ign_valid", 64'(out_valid), 64'd0);
    redirect_valid = 1'b0;

    // Reset from HALTED
    reset = 1'b1; out_ready = 1'b0;
    step();
    chk("rst_halt_clear", 64'(halted), 64'd0);
    chk("rst_halt_valid", 64'(out_valid), 64'd0);
    chk("rst_halt_addr", 64'(imem_addr), 64'd0);
    reset = 1'b0;

    // Halt loaded into DRAIN, then redirected away while stalled
    redirect_valid = 1'b1; redirect_pc = 5'd12;
    step();
    chk("pre_drain_valid", 64'(out_valid), 64'd0);
    chk("pre_drain_addr", 64'(imem_addr), 64'd12);
    redirect_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd1);
    chk("drain_pc", 64'(out_pc), 64'd12);
    chk("drain_addr", 64'(imem_addr), 64'd13);
    redirect_valid = 1'b1; redirect_pc = 5'd4;
    step();
    chk("drain_redir_valid", 64'(out_valid), 64'd0);
    chk("drain_redir_halted", 64'(halted), 64'd0);
    chk("drain_redir_addr", 64'(imem_addr), 64'd4);
    redirect_valid = 1'b0;
    step();
    chk("drain_resume_pc", 64'(out_pc), 64'd4);
    chk("drain_resume_instr", 64'(out_instr), 64'h3004);
    push(5'd4, 16'h3004, 16'h3005);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // PC wrap from 31 to 0
    redirect_valid = 1'b1; redirect_pc = 5'd30;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    push(5'd30, 16'h301E, 16'h301F);
    push(5'd31, 16'h301F, 16'h1007);
    step(); step(); step();
    out_ready = 1'b0;
    chk("wrap_pc", 64'(out_pc), 64'd0);
    chk("wrap_instr", 64'(out_instr), 64'h1007);
    chk("wrap_next", 64'(out_next), 64'h1102);
    step();
    chk("wrap_stall_pc", 64'(out_pc), 64'd0);

    // Reset mid-stall
    reset = 1'b1;
    step();
    chk("rst_stall_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_addr", 64'(imem_addr), 64'd0);
    chk("rst_stall_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    step(); step();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly upstream of the 16-bit, 32-entry instruction memory and downstream-feeding the decode stage.
- Owns the program counter and drives the memory address.
- Captures the returned instruction word and the following word into an output register.
- Hands the captured pair to decode over a valid/ready handshake; supports branch/jump redirect and halt-opcode detection.

Parameters:
- ADDR_W, 5, program-counter and memory address width; PC wraps modulo 2**ADDR_W.
- INSTR_W, 16, instruction word width.
- HALT_OPCODE, 4'b1110, value of instr[15:12] that marks the halt instruction.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  address to instruction memory; combinational copy of pc register.
- imem_instr  in  INSTR_W  word at imem_addr, same cycle (combinational memory).
- imem_next  in  INSTR_W  word at imem_addr+1, same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  target PC when redirect_valid=1.
- out_valid  out  1  output register holds an instruction for decode.
- out_ready  in  1  decode accepts the output this cycle.
- out_instr  out  INSTR_W  captured instruction.
- out_next  out  INSTR_W  captured following word.
- out_pc  out  ADDR_W  PC of out_instr.
- halted  out  1  halt instruction has been consumed; fetch frozen.

Behaviour:
- Reset (edge with reset=1, overrides everything):
  - pc=RESET_PC, out_valid=0, out_instr=0, out_next=0, out_pc=0, halted=0, state=RUN.
  - Reset asserted mid-stall or in HALTED returns to this state on that edge.
- Define accept = out_valid & out_ready; slot_free = ~out_valid | accept.
- State RUN, evaluated per edge in priority order:
  1. redirect_valid=1: pc<=redirect_pc; out_valid<=0 (flush, even if accept); no load this edge.
  2. slot_free: out_instr<=imem_instr, out_next<=imem_next, out_pc<=pc, out_valid<=1, pc<=pc+1 (5-bit wrap: 31 -> 0). If imem_instr[15:12]==HALT_OPCODE, go to DRAIN.
  3. else (stall: out_valid=1, out_ready=0): all registers hold; pc holds.
- State DRAIN (halt word sits in output register):
  - No further loads; pc holds.
  - redirect_valid=1: out_valid<=0, pc<=redirect_pc, return to RUN (halt was speculative).
  - accept without redirect: out_valid<=0, halted<=1, go to HALTED.
- State HALTED:
  - halted=1, out_valid=0, pc frozen.
  - redirect_valid and out_ready are ignored; only reset exits.
- Latency:
  - Address-to-output is 1 cycle: the word at pc appears on out_* the edge after the slot is free.
  - Back-to-back throughput is 1 instruction/cycle when out_ready=1.
  - First out_valid=1 occurs one cycle after reset deasserts.
- Output stability: while out_valid=1 and out_ready=0, out_instr/out_next/out_pc must not change; out_valid drops only via accept or redirect.
- out_next at pc=31 is whatever memory returns for the wrapped address; fetch does not interpret it.
- Simultaneous redirect and accept: the accepted instruction is consumed by decode; the output register is flushed and the target is fetched on the next edge.

Test Plan:
- Reset then out_ready=1 with program {0:16'h1007, 1:16'h1102, 2:16'h2000} -> out_valid rises 1 cycle after reset; out_pc/out_instr sequence 0/1007 (out_next=1102), 1/1102, 2/2000; imem_addr increments each cycle.
- Hold out_ready=0 for 3 cycles after first load -> out_instr stays 16'h1007, out_pc stays 0, imem_addr stays 1; after ready=1, stream resumes at pc 1 with no skip or duplicate.
- redirect_valid=1, redirect_pc=10 while out_pc=3 valid -> next edge out_valid=0; following edge out_pc=10, out_instr=mem[10].
- Program whose word 12 is 16'hE000, ready=1 -> after out_pc=12 is accepted, halted=1, out_valid=0, imem_addr frozen at 13; later redirect ignored.
- Halt word loaded into DRAIN with ready=0 while redirect_valid=1 to pc 4 -> returns to RUN, halted stays 0, out_pc=4 next.
- pc=31 fetch with ready=1 -> next out_pc=0 (wrap); assert reset mid-stall -> next edge out_valid=0, pc=0, halted=0.
